gpio_axi_wr_latch: RTL and testbench

- Parametrised AXI4-Lite write-channel front end for the GPIO peripheral.
- Accepts AW and W handshakes independently and in either order, and holds address and data in latches.
- Issues a single-cycle write strobe to the GPIO register bank, then returns the B response.
- Adds range checking (SLVERR), byte strobes and back-to-back throughput.

---
 rtl/gpio_axi_wr_latch.sv | 101 ++++++++++
 tb/tb_gpio_axi_wr_latch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_axi_wr_latch.sv
// rtl/gpio_axi_wr_latch.sv - AXI4-Lite write-channel front end for the GPIO register bank
// Independent AW/W latches pair up into a single-cycle wr_en, then a B response.
module gpio_axi_wr_latch #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32,
  parameter int NREG     = 8,
  parameter int CHECK_HI = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  AWvalid,
  output logic                  AWready,
  input  logic [31:0]           AWaddr,
  input  logic                  Wvalid,
  output logic                  Wready,
  input  logic [DATA_W-1:0]     Wdata,
  input  logic [DATA_W/8-1:0]   Wstrb,
  output logic                  Bvalid,
  input  logic                  Bready,
  output logic [1:0]            Bresp,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_strb
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W:0] NREG_L = (ADDR_W + 1)'(NREG);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                aw_full;
  logic                w_full;
  logic [ADDR_W-1:0]   addr_q;
  logic                err_q;
  logic [DATA_W-1:0]   data_q;
  logic [STRB_W-1:0]   strb_q;

  logic                aw_hs;
  logic                w_hs;
  logic                fire;
  logic [ADDR_W:0]     idx_ext;
  logic                idx_err;
  logic                hi_err;
  logic                addr_err;

  assign AWready = reset & ~aw_full;
  assign Wready  = reset & ~w_full;

  assign aw_hs = AWvalid & AWready;
  assign w_hs  = Wvalid & Wready;

  // Commit is blocked while an earlier response is still waiting on Bready.
  assign fire = reset & aw_full & w_full & (~Bvalid | Bready);

  assign idx_ext  = {1'b0, AWaddr[ADDR_W-1:0]};
  assign idx_err  = (idx_ext >= NREG_L);
  assign hi_err   = (CHECK_HI != 0) && (|AWaddr[31:ADDR_W]);
  assign addr_err = idx_err | hi_err;

  assign wr_en   = fire & ~err_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign wr_strb = strb_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      Bvalid  <= 1'b0;
      Bresp   <= RESP_OKAY;
    end else begin
      if (fire) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        Bvalid  <= 1'b1;
        Bresp   <= err_q ? RESP_SLVERR : RESP_OKAY;
      end else if (Bvalid && Bready) begin
        Bvalid  <= 1'b0;
      end

      // A handshake needs an empty latch, so it never coincides with fire.
      if (aw_hs) begin
        addr_q  <= AWaddr[ADDR_W-1:0];
        err_q   <= addr_err;
        aw_full <= 1'b1;
      end

      if (w_hs) begin
        data_q <= Wdata;
        strb_q <= Wstrb;
        w_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpio_axi_wr_latch.sv
// tb/tb_gpio_axi_wr_latch.sv - scoreboard bench for gpio_axi_wr_latch
// Two instances share stimulus: A (NREG=8, CHECK_HI=1) and B (NREG=6, CHECK_HI=0).
module tb_gpio_axi_wr_latch;

  logic        clock = 1'b0;
  logic        reset;
  logic        AWvalid;
  logic [31:0] AWaddr;
  logic        Wvalid;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Bready;

  logic        aw_ready_a, w_ready_a, b_valid_a, wr_en_a;
  logic [1:0]  b_resp_a;
  logic [2:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [3:0]  wr_strb_a;

  logic        aw_ready_b, w_ready_b, b_valid_b, wr_en_b;
  logic [1:0]  b_resp_b;
  logic [2:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [3:0]  wr_strb_b;

  always #5 clock = ~clock;

  gpio_axi_wr_latch #(.ADDR_W(3), .DATA_W(32), .NREG(8), .CHECK_HI(1)) dut_a (
    .clock(clock), .reset(reset),
    .AWvalid(AWvalid), .AWready(aw_ready_a), .AWaddr(AWaddr),
    .Wvalid(Wvalid), .Wready(w_ready_a), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(b_valid_a), .Bready(Bready), .Bresp(b_resp_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_strb(wr_strb_a)
  );

  gpio_axi_wr_latch #(.ADDR_W(3), .DATA_W(32), .NREG(6), .CHECK_HI(0)) dut_b (
    .clock(clock), .reset(reset),
    .AWvalid(AWvalid), .AWready(aw_ready_b), .AWaddr(AWaddr),
    .Wvalid(Wvalid), .Wready(w_ready_b), .Wdata(Wdata), .Wstrb(Wstrb),
    .Bvalid(b_valid_b), .Bready(Bready), .Bresp(b_resp_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_strb(wr_strb_b)
  );

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t        wq_a[$];
  wr_t        wq_b[$];
  logic [1:0] bq_a[$];
  logic [1:0] bq_b[$];
  wr_t        e_a, e_b;
  logic [1:0] r_a, r_b;

  int vectors     = 0;
  int miscompares = 0;
  int wr_cnt_a    = 0;
  int wr_cnt_b    = 0;
  int cyc         = 0;
  int last_wr_a   = -1;
  bit cadence     = 1'b0;
  int snap;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Expected result of one AW+W pair on both instances.
  function automatic void push_pair(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic err_a, err_b;
    err_a = |a[31:3];
    err_b = (a[2:0] >= 3'd6);
    if (!err_a) wq_a.push_back({a[2:0], d, s});
    if (!err_b) wq_b.push_back({a[2:0], d, s});
    bq_a.push_back(err_a ? 2'b10 : 2'b00);
    bq_b.push_back(err_b ? 2'b10 : 2'b00);
  endfunction

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (wr_en_a) begin
        wr_cnt_a++;
        if (wq_a.size() == 0) fail_now("wr_unexpected_a");
        else begin
          e_a = wq_a.pop_front();
          check("wr_addr_a", wr_addr_a, e_a.addr);
          check("wr_data_a", wr_data_a, e_a.data);
          check("wr_strb_a", wr_strb_a, e_a.strb);
        end
        if (cadence && last_wr_a >= 0) check("wr_gap_a", cyc - last_wr_a, 2);
        if (cadence) last_wr_a = cyc;
      end
      if (b_valid_a && Bready) begin
        if (bq_a.size() == 0) fail_now("b_unexpected_a");
        else begin
          r_a = bq_a.pop_front();
          check("bresp_a", b_resp_a, r_a);
        end
      end
      if (wr_en_b) begin
        wr_cnt_b++;
        if (wq_b.size() == 0) fail_now("wr_unexpected_b");
        else begin
          e_b = wq_b.pop_front();
          check("wr_addr_b", wr_addr_b, e_b.addr);
          check("wr_data_b", wr_data_b, e_b.data);
          check("wr_strb_b", wr_strb_b, e_b.strb);
        end
      end
      if (b_valid_b && Bready) begin
        if (bq_b.size() == 0) fail_now("b_unexpected_b");
        else begin
          r_b = bq_b.pop_front();
          check("bresp_b", b_resp_b, r_b);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_aw(input logic [31:0] a);
    AWaddr  = a;
    AWvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (aw_ready_a && aw_ready_b) begin
        @(posedge clock); #1;
        AWvalid = 1'b0;
        AWaddr  = $urandom;
        return;
      end
      @(posedge clock); #1;
    end
    fail_now("aw_timeout");
    AWvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    Wdata  = d;
    Wstrb  = s;
    Wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (w_ready_a && w_ready_b) begin
        @(posedge clock); #1;
        Wvalid = 1'b0;
        Wdata  = $urandom;
        Wstrb  = 4'($urandom);
        return;
      end
      @(posedge clock); #1;
    end
    fail_now("w_timeout");
    Wvalid = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    push_pair(a, d, s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (wq_a.size() == 0 && wq_b.size() == 0 && bq_a.size() == 0 && bq_b.size() == 0
          && !b_valid_a && !b_valid_b) return;
      @(posedge clock); #1;
    end
    fail_now("drain_timeout");
  endtask

  initial begin
    reset = 1'b0; AWvalid = 1'b0; AWaddr = '0; Wvalid = 1'b0;
    Wdata = '0; Wstrb = '0; Bready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_awready", aw_ready_a, 0);
    check("reset_wready", w_ready_a, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("post_reset_bvalid", b_valid_a, 0);
    check("post_reset_wr_en", wr_en_a, 0);
    check("post_reset_awready", aw_ready_a, 1);

    // Same-cycle AW/W, response held until Bready.
    send_pair(32'h5, 32'hDEADBEEF, 4'hF);
    check("t1_wr_en", wr_en_a, 1);
    @(posedge clock); #1;
    check("t1_bvalid", b_valid_a, 1);
    check("t1_bresp", b_resp_a, 2'b00);
    check("t1_wr_en_low", wr_en_a, 0);
    Bready = 1'b1;
    @(posedge clock); #1;
    check("t1_bvalid_clr", b_valid_a, 0);

    // W first, AW three cycles later.
    push_pair(32'h2, 32'h12345678, 4'hF);
    send_w(32'h12345678, 4'hF);
    snap = wr_cnt_a;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_gap", w_ready_a, 0);
      check("t2_no_wr", wr_cnt_a, snap);
      @(posedge clock); #1;
    end
    send_aw(32'h2);
    drain();

    // Range errors: index 6 (B only), high bits (A only).
    send_pair(32'h6, 32'hA5A5A5A5, 4'h3);
    send_pair(32'h100, 32'h0F0F0F0F, 4'hC);
    drain();

    // Response back-pressure with a second pair queued behind it.
    Bready = 1'b0;
    send_pair(32'h100, 32'h11111111, 4'h1);
    send_pair(32'h3, 32'h22222222, 4'h6);
    snap = wr_cnt_b;
    for (int i = 0; i < 5; i++) begin
      check("t4_awready", aw_ready_a, 0);
      check("t4_wready", w_ready_a, 0);
      check("t4_bvalid", b_valid_a, 1);
      check("t4_bresp_old", b_resp_a, 2'b10);
      check("t4_no_wr_en_b", wr_cnt_b, snap);
      @(posedge clock); #1;
    end
    Bready = 1'b1;
    #1;
    check("t4_wr_en_on_bready", wr_en_a, 1);
    @(posedge clock); #1;
    check("t4_bvalid_stays", b_valid_a, 1);
    check("t4_bresp_new", b_resp_a, 2'b00);
    drain();

    // Back-to-back writes at full rate.
    cadence = 1'b1;
    last_wr_a = -1;
    snap = wr_cnt_a;
    for (int i = 0; i < 10; i++)
      send_pair(32'(i % 8), 32'hC0DE0000 + 32'(i), 4'(i + 1));
    drain();
    cadence = 1'b0;
    check("t5_wr_count_a", wr_cnt_a - snap, 10);

    // Reset with only the AW latch full.
    send_aw(32'h4);
    check("t6_aw_full", aw_ready_a, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("t6_awready", aw_ready_a, 1);
    check("t6_wready", w_ready_a, 1);
    check("t6_bvalid", b_valid_a, 0);
    snap = wr_cnt_a;
    repeat (3) @(posedge clock);
    #1;
    check("t6_no_wr", wr_cnt_a, snap);
    send_pair(32'h4, 32'h44556677, 4'h9);
    drain();

    check("end_wq_a", wq_a.size(), 0);
    check("end_bq_b", bq_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
